blk_lum_grid: RTL and testbench

- Successor to the single-bit block classifier, one level per screen block.
- Accumulates weighted luma per block over a grid of HBLKS x VBLKS blocks.
- Quantises each block to an LVL_W-bit brightness level.
- Stores the levels in a double-buffered grid that downstream blocks (dark-mode inverter, overlay) read by address.
- Sits between the video input timing and the per-pixel transform stage.

---
 rtl/blk_pkg.sv | 34 +++
 rtl/blk_lum_grid_if.sv | 29 ++
 rtl/blk_quant.sv | 65 ++++++
 rtl/blk_lum_grid.sv | 143 ++++++++++++++
 tb/tb_blk_lum_grid.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/blk_pkg.sv
// Shared constants and helper functions for the block luma grid.
package blk_pkg;

  // Default luma weights, summing to 512.
  localparam int unsigned WR_DEF = 109;
  localparam int unsigned WG_DEF = 366;
  localparam int unsigned WB_DEF = 37;

  // Weighted luma of one pixel: 512*255 fits in 17 bits.
  localparam int unsigned LUMA_W = 17;

  // Accumulator width: $clog2(PXS*512*255+1).
  function automatic int unsigned acc_w(input int unsigned pxs);
    longint unsigned top;
    int unsigned     w;
    top = 64'(pxs) * 64'd130560 + 64'd1;
    w   = 0;
    while ((64'd1 << w) < top) w++;
    return w;
  endfunction

  // Threshold k of 2^lvl_w-1: k*PXS*512*256/2^lvl_w.
  function automatic longint unsigned lvl_thres(input int unsigned k, input int unsigned pxs,
                                                input int unsigned lvl_w);
    return (64'(k) * 64'(pxs) * 64'd131072) >> lvl_w;
  endfunction

  // Hysteresis margin in block-sum units.
  function automatic longint unsigned hyst_margin(input int unsigned hyst,
                                                  input int unsigned pxs);
    return 64'(hyst) * 64'(pxs) * 64'd512;
  endfunction

endpackage

// File: rtl/blk_lum_grid_if.sv
// Video input and level read port of the block luma grid.
interface blk_lum_grid_if #(
  parameter int unsigned HBLKS = 10,
  parameter int unsigned VBLKS = 10,
  parameter int unsigned LVL_W = 2
) ();
  localparam int unsigned XW = (HBLKS > 1) ? $clog2(HBLKS) : 1;
  localparam int unsigned YW = (VBLKS > 1) ? $clog2(VBLKS) : 1;

  logic             frame_start_i;
  logic             de_i;
  logic [23:0]      wd_i;
  logic             h_save_i;
  logic             v_save_i;
  logic [XW-1:0]    rd_x_i;
  logic [YW-1:0]    rd_y_i;
  logic [LVL_W-1:0] lvl_o;
  logic             frame_o;

  modport master (
    output frame_start_i, de_i, wd_i, h_save_i, v_save_i, rd_x_i, rd_y_i,
    input  lvl_o, frame_o
  );

  modport slave (
    input  frame_start_i, de_i, wd_i, h_save_i, v_save_i, rd_x_i, rd_y_i,
    output lvl_o, frame_o
  );
endinterface

// File: rtl/blk_quant.sv
// Block-sum quantiser: threshold comparator chain, registered level.
// BLK_LVL_HYST_EN adds hysteresis against the previous level prev_i.
module blk_quant import blk_pkg::*; #(
  parameter int unsigned PXS   = 900,
  parameter int unsigned LVL_W = 2,
  parameter int unsigned ACC_W = 27,
  parameter int unsigned HYST  = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [ACC_W-1:0] sum_i,
`ifdef BLK_LVL_HYST_EN
  input  logic [LVL_W-1:0] prev_i,
`endif
  output logic [LVL_W-1:0] lvl_o
);
  localparam int unsigned NLVL = 32'd1 << LVL_W;

  logic [NLVL-1:1]  ge;
  logic [LVL_W-1:0] raw;
  logic [LVL_W-1:0] lvl_d;

`ifdef BLK_LVL_HYST_EN
  localparam longint unsigned Margin = hyst_margin(HYST, PXS);
  logic [NLVL-1:0] up;
  logic [NLVL-1:0] dn;
  assign up[0] = 1'b0;
  assign dn[0] = 1'b0;
`endif

  for (genvar k = 1; k < NLVL; k++) begin : g_thr
    localparam longint unsigned Thr = lvl_thres(k, PXS, LVL_W);
    assign ge[k] = 64'(sum_i) >= Thr;
`ifdef BLK_LVL_HYST_EN
    assign up[k] = 64'(sum_i) >= Thr + Margin;
    assign dn[k] = 64'(sum_i) + Margin <= Thr;
`endif
  end

  // Thresholds are monotonic, so the highest one met is the level.
  always_comb begin
    raw = '0;
    for (int k = 1; k < int'(NLVL); k++) begin
      if (ge[k]) raw = LVL_W'(k);
    end
  end

  // Single-step moves must clear the crossed threshold by the margin.
  always_comb begin
    lvl_d = raw;
`ifdef BLK_LVL_HYST_EN
    if (int'(raw) == int'(prev_i) + 1) begin
      if (!up[raw]) lvl_d = prev_i;
    end else if (int'(raw) + 1 == int'(prev_i)) begin
      if (!dn[prev_i]) lvl_d = prev_i;
    end
`endif
  end

  // Level register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lvl_o <= '0;
    else         lvl_o <= lvl_d;
  end
endmodule

// File: rtl/blk_lum_grid.sv
// Per-block mean-luma quantiser with a double-buffered level grid.
// Optional BLK_LVL_HYST_EN: quantiser hysteresis against the front bank.
module blk_lum_grid import blk_pkg::*; #(
  parameter int unsigned HBLKS = 10,
  parameter int unsigned VBLKS = 10,
  parameter int unsigned PXS   = 900,
  parameter int unsigned LVL_W = 2,
  parameter int unsigned WR    = WR_DEF,
  parameter int unsigned WG    = WG_DEF,
  parameter int unsigned WB    = WB_DEF,
  parameter int unsigned HYST  = 8
) (
  input logic           clk_i,
  input logic           rst_ni,
  blk_lum_grid_if.slave bus
);
  localparam int unsigned ACC_W = acc_w(PXS);
  localparam int unsigned XW    = (HBLKS > 1) ? $clog2(HBLKS) : 1;
  localparam int unsigned YW    = (VBLKS > 1) ? $clog2(VBLKS) : 1;

  logic [LUMA_W-1:0] luma_d, luma_q;
  logic              de_q, hs_q, vs_q;
  logic [ACC_W-1:0]  acc_q [HBLKS];
  logic [ACC_W-1:0]  head_sum;
  logic [XW-1:0]     col_q, wr_col_q;
  logic [YW-1:0]     row_q, wr_row_q;
  logic              col_wrap, row_last, launch, wr_en;
  logic              wr_vld_q, swap_pend_q, sel_q, frame_q;
  logic [LVL_W-1:0]  bank_q [2][VBLKS][HBLKS];
  logic [LVL_W-1:0]  q_lvl, lvl_q;

  assign luma_d = LUMA_W'(WR) * LUMA_W'(bus.wd_i[23:16])
                + LUMA_W'(WG) * LUMA_W'(bus.wd_i[15:8])
                + LUMA_W'(WB) * LUMA_W'(bus.wd_i[7:0]);

  // Input stage: luma and strobes delayed together by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      luma_q <= '0;
      de_q   <= 1'b0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
    end else begin
      luma_q <= luma_d;
      de_q   <= bus.de_i;
      hs_q   <= bus.h_save_i;
      vs_q   <= bus.v_save_i;
    end
  end

  // The ring head is acc_q[col_q]; a pixel on the h_save cycle still counts.
  assign head_sum = acc_q[col_q] + (de_q ? ACC_W'(luma_q) : '0);
  assign col_wrap = int'(col_q) == int'(HBLKS) - 1;
  assign row_last = int'(row_q) == int'(VBLKS) - 1;
  assign launch   = hs_q & vs_q & ~bus.frame_start_i;

  // Accumulator ring and block counters; frame_start resynchronises them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(HBLKS); i++) acc_q[i] <= '0;
      col_q <= '0;
      row_q <= '0;
    end else if (bus.frame_start_i) begin
      for (int i = 0; i < int'(HBLKS); i++) acc_q[i] <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      if (hs_q && vs_q)  acc_q[col_q] <= '0;
      else if (de_q)     acc_q[col_q] <= head_sum;
      if (hs_q) begin
        col_q <= col_wrap ? '0 : col_q + 1'b1;
        if (vs_q && col_wrap) row_q <= row_last ? '0 : row_q + 1'b1;
      end
    end
  end

  // Write address and swap request follow the quantiser by one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_vld_q    <= 1'b0;
      wr_col_q    <= '0;
      wr_row_q    <= '0;
      swap_pend_q <= 1'b0;
    end else begin
      wr_vld_q    <= launch;
      wr_col_q    <= col_q;
      wr_row_q    <= row_q;
      swap_pend_q <= launch & col_wrap & row_last;
    end
  end

`ifdef BLK_LVL_HYST_EN
  logic [LVL_W-1:0] prev_lvl;
  assign prev_lvl = bank_q[sel_q][row_q][col_q];
`endif

  blk_quant #(
    .PXS   (PXS),
    .LVL_W (LVL_W),
    .ACC_W (ACC_W),
    .HYST  (HYST)
  ) u_quant (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .sum_i  (head_sum),
`ifdef BLK_LVL_HYST_EN
    .prev_i (prev_lvl),
`endif
    .lvl_o  (q_lvl)
  );

  // A frame_start drops the pending write unless it carries the bank swap.
  assign wr_en = wr_vld_q & (~bus.frame_start_i | swap_pend_q);

  // Level banks, front select and swap pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < 2; b++)
        for (int y = 0; y < int'(VBLKS); y++)
          for (int x = 0; x < int'(HBLKS); x++) bank_q[b][y][x] <= '0;
      sel_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= swap_pend_q;
      if (swap_pend_q) sel_q <= ~sel_q;
      if (wr_en) bank_q[~sel_q][wr_row_q][wr_col_q] <= q_lvl;
    end
  end

  // Registered user read from the front bank; out of range reads 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvl_q <= '0;
    end else if (int'(bus.rd_x_i) < int'(HBLKS) && int'(bus.rd_y_i) < int'(VBLKS)) begin
      lvl_q <= bank_q[sel_q][bus.rd_y_i][bus.rd_x_i];
    end else begin
      lvl_q <= '0;
    end
  end

  assign bus.lvl_o   = lvl_q;
  assign bus.frame_o = frame_q;
endmodule

// File: tb/tb_blk_lum_grid.sv
// Directed bench for blk_lum_grid on a 2x2 grid of 2x2-pixel blocks.
module tb_blk_lum_grid;
`ifdef BLK_LVL_HYST_EN
  localparam int HystOn = 1;
`else
  localparam int HystOn = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fs, de, hs, vs, rx, ry;
  logic [23:0] wd;
  int          n_chk = 0;
  int          n_pass = 0;
  int          fcnt = 0;

  always #5 clk = ~clk;

  blk_lum_grid_if #(.HBLKS(2), .VBLKS(2), .LVL_W(2)) bus2 ();
  blk_lum_grid_if #(.HBLKS(2), .VBLKS(2), .LVL_W(1)) bus1 ();

  assign bus2.frame_start_i = fs;
  assign bus2.de_i          = de;
  assign bus2.wd_i          = wd;
  assign bus2.h_save_i      = hs;
  assign bus2.v_save_i      = vs;
  assign bus2.rd_x_i        = rx;
  assign bus2.rd_y_i        = ry;
  assign bus1.frame_start_i = fs;
  assign bus1.de_i          = de;
  assign bus1.wd_i          = wd;
  assign bus1.h_save_i      = hs;
  assign bus1.v_save_i      = vs;
  assign bus1.rd_x_i        = rx;
  assign bus1.rd_y_i        = ry;

  blk_lum_grid #(.HBLKS(2), .VBLKS(2), .PXS(4), .LVL_W(2), .HYST(8)) dut2 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus2.slave)
  );

  blk_lum_grid #(.HBLKS(2), .VBLKS(2), .PXS(4), .LVL_W(1), .HYST(8)) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus1.slave)
  );

  always @(negedge clk) if (bus2.frame_o) fcnt++;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      fs = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0;
    end
  endtask

  task automatic pix(input logic [7:0] g, input logic h, input logic v);
    @(negedge clk);
    fs = 1'b0; de = 1'b1; wd = {g, g, g}; hs = h; vs = v;
  endtask

  // One video line: two pixels of block 0, then two of block 1.
  task automatic line(input logic [7:0] g0, input logic [7:0] g1, input logic v);
    pix(g0, 1'b0, v); pix(g0, 1'b1, v);
    pix(g1, 1'b0, v); pix(g1, 1'b1, v);
    idle(2);
  endtask

  task automatic pulse_fs;
    @(negedge clk);
    fs = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0;
    idle(1);
  endtask

  // Uniform blocks a,b (row 0) and c,d (row 1).
  task automatic frame(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    pulse_fs();
    line(a, b, 1'b0); line(a, b, 1'b1);
    line(c, d, 1'b0); line(c, d, 1'b1);
  endtask

  task automatic wait_frame(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus2.frame_o) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, int'(seen), 1);
  endtask

  task automatic rd2(input string tag, input int x, input int y, input int exp);
    @(negedge clk); rx = 1'(x); ry = 1'(y);
    @(negedge clk); check(tag, int'(bus2.lvl_o), exp);
  endtask

  task automatic rd1(input string tag, input int x, input int y, input int exp);
    @(negedge clk); rx = 1'(x); ry = 1'(y);
    @(negedge clk); check(tag, int'(bus1.lvl_o), exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int f0;
    fs = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0; wd = '0; rx = 1'b1; ry = 1'b1;
    idle(3);
    check("reset lvl_o", int'(bus2.lvl_o), 0);
    check("reset frame_o", int'(bus2.frame_o), 0);
    rst_n = 1'b1;
    rd2("first frame reads 0", 1, 1, 0);

    // Grey grid.
    frame(8'h20, 8'h60, 8'hA0, 8'hFF);
    wait_frame("grid frame_o");
    rd2("grid 0x20", 0, 0, 0);
    rd2("grid 0x60", 1, 0, 1);
    rd2("grid 0xA0", 0, 1, 2);
    rd2("grid 0xFF", 1, 1, 3);

    // T_1 is met only if the h_save pixel itself is counted.
    frame(8'h40, 8'h3F, 8'h3F, 8'h40);
    wait_frame("thr frame_o");
    rd2("thr 0x40", 0, 0, 1);
    rd2("thr 0x3F", 1, 0, 0);
    rd1("thr1 0x40", 0, 0, 0);
    frame(8'h80, 8'h7F, 8'h7F, 8'h80);
    wait_frame("thr1 frame_o");
    rd1("thr1 0x80", 0, 0, 1);
    rd1("thr1 0x7F", 1, 0, 0);
    rd1("thr1 0x80 b", 1, 1, 1);
    rd2("thr2 0x7F", 0, 1, 1);

    // Partial sums survive a rotation without v_save.
    pulse_fs();
    line(8'hFF, 8'hC0, 1'b0); line(8'h00, 8'hC0, 1'b1);
    line(8'h20, 8'h20, 1'b0); line(8'h20, 8'h20, 1'b1);
    wait_frame("rot frame_o");
    rd2("rot two-line mean", 0, 0, 1);
    rd2("rot 0xC0", 1, 0, 3);
    rd2("rot 0x20", 0, 1, 0);

    // Double buffer and swap-cycle read.
    frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    wait_frame("dbuf A frame_o");
    rd2("dbuf A", 0, 0, 3);
    frame(8'h00, 8'h00, 8'h00, 8'h00);
    check("dbuf before swap", int'(bus2.lvl_o), 3);
    wait_frame("dbuf B frame_o");
    check("dbuf swap-cycle read", int'(bus2.lvl_o), 3);
    @(negedge clk);
    check("dbuf after swap", int'(bus2.lvl_o), 0);

    // frame_start part way through row 1.
    f0 = fcnt;
    pulse_fs();
    line(8'hFF, 8'hFF, 1'b0); line(8'hFF, 8'hFF, 1'b1);
    line(8'hFF, 8'hFF, 1'b0);
    frame(8'h60, 8'hA0, 8'h20, 8'h60);
    wait_frame("fs frame_o");
    idle(10);
    check("fs one frame_o", fcnt - f0, 1);
    rd2("fs (0,0)", 0, 0, 1);
    rd2("fs (1,0)", 1, 0, 2);
    rd2("fs (0,1) no stale", 0, 1, 0);
    rd2("fs (1,1)", 1, 1, 1);

    // Asynchronous reset mid-frame.
    rd2("pre-reset (1,0)", 1, 0, 2);
    pulse_fs();
    line(8'hFF, 8'hFF, 1'b0); line(8'hFF, 8'hFF, 1'b1);
    pix(8'hFF, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    idle(2);
    check("mid reset lvl_o", int'(bus2.lvl_o), 0);
    check("mid reset frame_o", int'(bus2.frame_o), 0);
    rst_n = 1'b1;
    rd2("post-reset (1,0)", 1, 0, 0);
    frame(8'hFF, 8'h20, 8'h60, 8'hA0);
    wait_frame("post-reset frame_o");
    rd2("post-reset (0,0)", 0, 0, 3);
    rd2("post-reset (1,1)", 1, 1, 2);

    // Hysteresis sequence (plain quantiser expectations otherwise).
    frame(8'h60, 8'h60, 8'h60, 8'h60);
    wait_frame("hyst base frame_o");
    rd2("hyst base 0x60", 0, 0, 1);
    frame(8'h84, 8'h84, 8'h84, 8'h84);
    wait_frame("hyst 0x84 frame_o");
    rd2("hyst 0x84", 0, 0, HystOn ? 1 : 2);
    frame(8'h90, 8'h90, 8'h90, 8'h90);
    wait_frame("hyst 0x90 frame_o");
    rd2("hyst 0x90", 1, 1, 2);
    frame(8'h00, 8'h00, 8'h00, 8'h00);
    wait_frame("hyst 0x00 frame_o");
    rd2("hyst 0x00", 0, 0, 0);
    frame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
    wait_frame("hyst 0xC0 frame_o");
    rd2("hyst 0xC0 jump", 0, 0, 3);
    frame(8'hBC, 8'hBC, 8'hBC, 8'hBC);
    wait_frame("hyst 0xBC frame_o");
    rd2("hyst 0xBC", 1, 0, HystOn ? 3 : 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
